// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: passive monitor for a multiplexed 4-digit
// common-anode 7-segment bus. It waits for each digit slot to settle,
// decodes the glyph back to BCD and assembles the four digits into frames.
// Optional feature macro: SEG_HEX_EN (accept hex glyphs A..F).
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] bcd_value,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic        pattern_err,
  output logic        anode_err
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W = 11;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t state, state_nxt;

  logic [SMP_W-1:0] smp_c;
  logic [SMP_W-1:0] prev;
  logic [CNT_W-1:0] stable_cnt;
  logic             capture_c;

  logic [3:0][3:0]  work, work_nxt;
  logic [3:0]       seen, seen_nxt;
  logic [15:0]      bcd_nxt, frame_cnt_nxt;
  logic             frame_valid_nxt, pattern_err_nxt, anode_err_nxt;

  logic             anode_slot, anode_bad;
  logic [1:0]       slot;
  logic [4:0]       glyph;

  // Active-low glyph to {legal, digit}
  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0010000: r = {1'b1, 4'h9};
`ifdef SEG_HEX_EN
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
`endif
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign smp_c     = {an, seg};
  // Strobe on the edge where the run of equal samples reaches SETTLE_CYCLES
  assign capture_c = (smp_c == prev) && (stable_cnt == (CNT_MAX - CNT_ONE));
  assign glyph     = glyph_decode(seg);

  // Stability filter: count consecutive equal samples, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      stable_cnt <= '0;
    end else begin
      prev <= smp_c;
      if (smp_c == prev) begin
        if (stable_cnt != CNT_MAX) stable_cnt <= stable_cnt + CNT_ONE;
      end else begin
        stable_cnt <= CNT_ONE;
      end
    end
  end

  // Anode classification: one-hot-low selects a slot, all-high is blanking
  always_comb begin
    anode_slot = 1'b0;
    anode_bad  = 1'b0;
    slot       = 2'd0;
    case (an)
      4'b1110: begin anode_slot = 1'b1; slot = 2'd0; end
      4'b1101: begin anode_slot = 1'b1; slot = 2'd1; end
      4'b1011: begin anode_slot = 1'b1; slot = 2'd2; end
      4'b0111: begin anode_slot = 1'b1; slot = 2'd3; end
      4'b1111: anode_bad = 1'b0;
      default: anode_bad = 1'b1;
    endcase
  end

  // Frame assembly next-state and registered-output logic
  always_comb begin
    state_nxt       = state;
    work_nxt        = work;
    seen_nxt        = seen;
    bcd_nxt         = bcd_value;
    frame_cnt_nxt   = frame_cnt;
    frame_valid_nxt = 1'b0;
    pattern_err_nxt = 1'b0;
    anode_err_nxt   = 1'b0;
    case (state)
      COLLECT: begin
        if (capture_c) begin
          if (anode_bad) begin
            anode_err_nxt = 1'b1;
          end else if (anode_slot) begin
            if (glyph[4]) begin
              work_nxt[slot] = glyph[3:0];
              seen_nxt[slot] = 1'b1;
              if (seen_nxt == 4'b1111) begin
                state_nxt       = EMIT;
                frame_valid_nxt = 1'b1;
                bcd_nxt         = work_nxt;
                frame_cnt_nxt   = frame_cnt + 16'd1;
              end
            end else begin
              pattern_err_nxt = 1'b1;
            end
          end
        end
      end
      EMIT: begin
        seen_nxt  = 4'b0000;
        state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      work        <= '0;
      seen        <= '0;
      bcd_value   <= '0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      work        <= work_nxt;
      seen        <= seen_nxt;
      bcd_value   <= bcd_nxt;
      frame_cnt   <= frame_cnt_nxt;
      frame_valid <= frame_valid_nxt;
      pattern_err <= pattern_err_nxt;
      anode_err   <= anode_err_nxt;
    end
  end

  // The settle filter needs at least two cycles, so EMIT never sees a capture
  a_no_capture_in_emit: assert property (@(posedge clk) disable iff (rst)
    (state == EMIT) |-> !capture_c);

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder (SETTLE_CYCLES = 16).
module tb_seven_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd_value;
  logic        frame_valid;
  logic [15:0] frame_cnt;
  logic        pattern_err;
  logic        anode_err;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .bcd_value   (bcd_value),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .pattern_err (pattern_err),
    .anode_err   (anode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    int          fv;
    int          pe;
    int          ae;
    bit          chk;
    logic [15:0] bcd;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold {an,seg} for a number of cycles, counting output pulses at negedge
  task automatic hold_step(input logic [3:0] a, input logic [6:0] s, input int n,
                           output int fvc, output int pec, output int aec);
    fvc = 0; pec = 0; aec = 0;
    an  = a;
    seg = s;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (frame_valid) fvc++;
      if (pattern_err) pec++;
      if (anode_err)   aec++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int fvc, pec, aec;
    int fv_t, pe_t, ae_t;

    //            an       seg         hold fv pe ae chk bcd       cnt
    vecs[0]  = '{4'b1110, 7'b0011001, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[1]  = '{4'b1101, 7'b0110000, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[2]  = '{4'b1011, 7'b0100100, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[3]  = '{4'b0111, 7'b1111001, 20, 1, 0, 0, 1, 16'h1234, 16'd1};
    vecs[4]  = '{4'b1110, 7'b0010000, 20, 0, 0, 0, 0, 16'h1234, 16'd1};
    vecs[5]  = '{4'b1110, 7'b1000000, 10, 0, 0, 0, 1, 16'h1234, 16'd1};
    vecs[6]  = '{4'b1101, 7'b0000000, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[7]  = '{4'b1011, 7'b1111000, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[8]  = '{4'b0111, 7'b0000010, 20, 1, 0, 0, 1, 16'h6789, 16'd2};
    vecs[9]  = '{4'b1101, 7'b1111110, 40, 0, 1, 0, 0, 16'h0000, 16'd0};
    vecs[10] = '{4'b1110, 7'b0010010, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[11] = '{4'b1011, 7'b0100100, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[12] = '{4'b0111, 7'b1111001, 20, 0, 0, 0, 1, 16'h6789, 16'd2};
    vecs[13] = '{4'b1100, 7'b1111001, 20, 0, 0, 1, 0, 16'h0000, 16'd0};
    vecs[14] = '{4'b1111, 7'b0000000, 20, 0, 0, 0, 1, 16'h6789, 16'd2};
    vecs[15] = '{4'b1110, 7'b0011001, 20, 0, 0, 0, 0, 16'h0000, 16'd0};
    vecs[16] = '{4'b1101, 7'b0110000, 20, 1, 0, 0, 1, 16'h1234, 16'd3};

    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    repeat (3) @(negedge clk);
    check("rst bcd_value",   32'(bcd_value),   32'h0);
    check("rst frame_valid", 32'(frame_valid), 32'h0);
    check("rst frame_cnt",   32'(frame_cnt),   32'h0);
    check("rst pattern_err", 32'(pattern_err), 32'h0);
    check("rst anode_err",   32'(anode_err),   32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      hold_step(vecs[i].an, vecs[i].seg, vecs[i].hold, fvc, pec, aec);
      check($sformatf("v%0d frame_valid pulses", i), 32'(fvc), 32'(vecs[i].fv));
      check($sformatf("v%0d pattern_err pulses", i), 32'(pec), 32'(vecs[i].pe));
      check($sformatf("v%0d anode_err pulses", i),   32'(aec), 32'(vecs[i].ae));
      if (vecs[i].chk) begin
        check($sformatf("v%0d bcd_value", i), 32'(bcd_value), 32'(vecs[i].bcd));
        check($sformatf("v%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].cnt));
      end
    end

    // Reset mid-frame: slots 0-2 captured, reset, then slot 3 alone
    fv_t = 0;
    hold_step(4'b1110, 7'b0011001, 20, fvc, pec, aec); fv_t += fvc;
    hold_step(4'b1101, 7'b0110000, 20, fvc, pec, aec); fv_t += fvc;
    hold_step(4'b1011, 7'b0100100, 20, fvc, pec, aec); fv_t += fvc;
    pulse_reset();
    hold_step(4'b0111, 7'b1111001, 20, fvc, pec, aec); fv_t += fvc;
    check("midreset frame_valid pulses", 32'(fv_t), 32'd0);
    check("midreset bcd_value", 32'(bcd_value), 32'h0);
    check("midreset frame_cnt", 32'(frame_cnt), 32'h0);

    // Hex glyph 'A' on all four slots
    pulse_reset();
    fv_t = 0; pe_t = 0; ae_t = 0;
    hold_step(4'b1110, 7'b0001000, 20, fvc, pec, aec); fv_t += fvc; pe_t += pec; ae_t += aec;
    hold_step(4'b1101, 7'b0001000, 20, fvc, pec, aec); fv_t += fvc; pe_t += pec; ae_t += aec;
    hold_step(4'b1011, 7'b0001000, 20, fvc, pec, aec); fv_t += fvc; pe_t += pec; ae_t += aec;
    hold_step(4'b0111, 7'b0001000, 20, fvc, pec, aec); fv_t += fvc; pe_t += pec; ae_t += aec;
    check("hex anode_err pulses", 32'(ae_t), 32'd0);
`ifdef SEG_HEX_EN
    check("hex frame_valid pulses", 32'(fv_t), 32'd1);
    check("hex pattern_err pulses", 32'(pe_t), 32'd0);
    check("hex bcd_value", 32'(bcd_value), 32'hAAAA);
    check("hex frame_cnt", 32'(frame_cnt), 32'd1);
`else
    check("hex frame_valid pulses", 32'(fv_t), 32'd0);
    check("hex pattern_err pulses", 32'(pe_t), 32'd4);
    check("hex bcd_value", 32'(bcd_value), 32'h0);
    check("hex frame_cnt", 32'(frame_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
